// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM.
// Steps each instruction through fetch, decode, execute, memory and writeback.
// On each step it drives the datapath mux selects, the strobes and the ALU control code.
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   instr             - instruction register contents, stable from DECODE onward
//   mem_ready         - memory access completes this cycle
//   ir_write/pc_write - IR / PC load strobes
//   mem_write         - memory write request
//   reg_write         - register-file write strobe
//   adr_src, alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src - datapath selects
//   instr_done        - pulse in the final cycle of each legal instruction
//   illegal_instr     - pulse when DECODE rejects the instruction
//   state             - current state, for debug
module multicycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic               adr_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_ctrl,
  output logic [1:0]         result_src,
  output logic [1:0]         imm_src,
  output logic               instr_done,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_EXECUTER = STATE_W'(2),
    S_EXECUTEI = STATE_W'(3),
    S_ALUWB    = STATE_W'(4),
    S_MEMADR   = STATE_W'(5),
    S_MEMREAD  = STATE_W'(6),
    S_MEMWB    = STATE_W'(7),
    S_MEMWRITE = STATE_W'(8),
    S_BRANCH   = STATE_W'(9)
  } state_e;

  state_e state_q, state_d;

  // Instruction fields
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       l_bit;
  logic       u_bit;

  assign op    = instr[27:26];
  assign i_bit = instr[25];
  assign cmd   = instr[24:21];
  assign l_bit = instr[20];
  assign u_bit = instr[23];

  // Condition field and operand fields are not needed for control
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:28], instr[19:0]};

  // Data-processing cmd to ALU code
  logic [1:0] dp_code;
  logic       dp_legal;

  always_comb begin
    dp_code  = 2'd0;
    dp_legal = 1'b1;
    case (cmd)
      4'b0100: dp_code = 2'd0;
      4'b0010: dp_code = 2'd1;
      4'b0000: dp_code = 2'd2;
      4'b1100: dp_code = 2'd3;
      default: dp_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Next-state and Moore outputs; strobes are masked while reset is high
  always_comb begin
    state_d       = state_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_ctrl      = 2'd0;
    result_src    = 2'd0;
    imm_src       = 2'd0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        case (op)
          2'b00: begin
            if (dp_legal) begin
              state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
            end else begin
              illegal_instr = 1'b1;
              state_d       = S_FETCH;
            end
          end
          2'b01: begin
            imm_src = 2'd1;
            state_d = S_MEMADR;
          end
          2'b10: begin
            imm_src = 2'd2;
            state_d = S_BRANCH;
          end
          default: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_EXECUTER: begin
        alu_src_b = 2'd0;
        alu_ctrl  = dp_code;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_b = 2'd1;
        imm_src   = 2'd0;
        alu_ctrl  = dp_code;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = 2'd0;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_b = 2'd1;
        imm_src   = 2'd1;
        alu_ctrl  = u_bit ? 2'd0 : 2'd1;
        state_d   = l_bit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'd1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd1;
        imm_src    = 2'd2;
        alu_ctrl   = 2'd0;
        result_src = 2'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (reset) begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// An instruction-level model expands each instruction into its expected per-cycle output vectors.
// Those vectors are compared against the DUT in lockstep.
module tb_multicycle_ctrl;

  localparam int unsigned STATE_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        instr;
  logic               mem_ready;
  logic               ir_write, pc_write, mem_write, reg_write;
  logic               adr_src, alu_src_a;
  logic [1:0]         alu_src_b, alu_ctrl, result_src, imm_src;
  logic               instr_done, illegal_instr;
  logic [STATE_W-1:0] unused_state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.STATE_W(STATE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .adr_src      (adr_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_ctrl     (alu_ctrl),
    .result_src   (result_src),
    .imm_src      (imm_src),
    .instr_done   (instr_done),
    .illegal_instr(illegal_instr),
    .state        (unused_state)
  );

  typedef struct packed {
    logic       ir_w;
    logic       pc_w;
    logic       mem_w;
    logic       reg_w;
    logic       adr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluc;
    logic [1:0] res;
    logic [1:0] imm;
    logic       done;
    logic       ill;
  } vec_t;

  vec_t act;
  assign act = {ir_write, pc_write, mem_write, reg_write, adr_src, alu_src_a,
                alu_src_b, alu_ctrl, result_src, imm_src, instr_done, illegal_instr};

  int checks = 0;
  int errors = 0;

  vec_t exp_q[$];
  logic rdy_q[$];

  function automatic vec_t fetch_vec(input logic rdy);
    vec_t e = '0;
    e.srca = 1'b1;
    e.srcb = 2'd2;
    e.res  = 2'd2;
    e.ir_w = rdy;
    e.pc_w = rdy;
    return e;
  endfunction

  // Returns 1 when the data-processing cmd is supported, with its ALU code
  function automatic logic dp_decode(input logic [3:0] cmd, output logic [1:0] code);
    code = 2'd0;
    if (cmd == 4'b0100) begin code = 2'd0; return 1'b1; end
    if (cmd == 4'b0010) begin code = 2'd1; return 1'b1; end
    if (cmd == 4'b0000) begin code = 2'd2; return 1'b1; end
    if (cmd == 4'b1100) begin code = 2'd3; return 1'b1; end
    return 1'b0;
  endfunction

  // Expand one instruction into expected vectors plus the mem_ready to drive each cycle
  task automatic build(input logic [31:0] ins, input int fstall, input int mstall);
    vec_t       e;
    logic [1:0] op;
    logic [1:0] code;
    logic       ok;
    op = ins[27:26];
    ok = dp_decode(ins[24:21], code);
    exp_q.delete();
    rdy_q.delete();
    for (int k = 0; k < fstall; k++) begin
      exp_q.push_back(fetch_vec(1'b0));
      rdy_q.push_back(1'b0);
    end
    exp_q.push_back(fetch_vec(1'b1));
    rdy_q.push_back(1'b1);
    // decode
    e      = '0;
    e.srca = 1'b1;
    e.srcb = 2'd2;
    e.imm  = (op == 2'b11) ? 2'd0 : op;
    ok     = (op == 2'b01) || (op == 2'b10) || ((op == 2'b00) && ok);
    e.ill  = !ok;
    exp_q.push_back(e);
    rdy_q.push_back(1'($urandom_range(0, 1)));
    if (!ok) return;
    if (op == 2'b00) begin
      e      = '0;
      e.srcb = {1'b0, ins[25]};
      e.aluc = code;
      exp_q.push_back(e);
      rdy_q.push_back(1'($urandom_range(0, 1)));
      e       = '0;
      e.reg_w = 1'b1;
      e.done  = 1'b1;
      exp_q.push_back(e);
      rdy_q.push_back(1'($urandom_range(0, 1)));
    end else if (op == 2'b01) begin
      e      = '0;
      e.srcb = 2'd1;
      e.imm  = 2'd1;
      e.aluc = ins[23] ? 2'd0 : 2'd1;
      exp_q.push_back(e);
      rdy_q.push_back(1'($urandom_range(0, 1)));
      for (int k = 0; k < mstall; k++) begin
        e       = '0;
        e.adr   = 1'b1;
        e.mem_w = !ins[20];
        exp_q.push_back(e);
        rdy_q.push_back(1'b0);
      end
      e       = '0;
      e.adr   = 1'b1;
      e.mem_w = !ins[20];
      e.done  = !ins[20];
      exp_q.push_back(e);
      rdy_q.push_back(1'b1);
      if (ins[20]) begin
        e       = '0;
        e.res   = 2'd1;
        e.reg_w = 1'b1;
        e.done  = 1'b1;
        exp_q.push_back(e);
        rdy_q.push_back(1'($urandom_range(0, 1)));
      end
    end else begin
      e      = '0;
      e.srca = 1'b1;
      e.srcb = 2'd1;
      e.imm  = 2'd2;
      e.res  = 2'd2;
      e.pc_w = 1'b1;
      e.done = 1'b1;
      exp_q.push_back(e);
      rdy_q.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  // Run one instruction from FETCH; rst_at >= 0 asserts reset in that cycle and abandons the rest
  task automatic run_instr(input string name, input logic [31:0] ins, input int fstall,
                           input int mstall, input int rst_at);
    vec_t e;
    build(ins, fstall, mstall);
    instr = ins;
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = rdy_q[i];
      reset     = (i == rst_at);
      e         = exp_q[i];
      if (reset) begin
        e.ir_w = 1'b0; e.pc_w = 1'b0; e.mem_w = 1'b0;
        e.reg_w = 1'b0; e.done = 1'b0; e.ill = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s cycle %0d instr %h: got %h expected %h", name, i, ins, act, e);
      end
      @(posedge clk);
      #1;
      if (reset) begin
        reset = 1'b0;
        break;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [3:0]  cmds[4];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
    ins  = $urandom;
    if ($urandom_range(0, 3) != 0) ins[24:21] = cmds[$urandom_range(0, 3)];
    return ins;
  endfunction

  task automatic test_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    instr     = 32'hE0821003;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({ir_write, pc_write, mem_write, reg_write, instr_done, illegal_instr} !== 6'b0) begin
        errors++;
        $display("FAIL reset_strobes cycle %0d: got %b expected 000000", i,
                 {ir_write, pc_write, mem_write, reg_write, instr_done, illegal_instr});
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_dp();
    run_instr("add_reg", 32'hE0821003, 0, 0, -1);
    run_instr("sub_imm", 32'hE2411001, 0, 0, -1);
    run_instr("and_reg", 32'hE0021003, 1, 0, -1);
    run_instr("orr_imm", 32'hE38110FF, 2, 0, -1);
  endtask

  task automatic test_mem();
    run_instr("ldr_stall", 32'hE5910004, 0, 2, -1);
    run_instr("str_stall", 32'hE5810004, 0, 2, -1);
    run_instr("ldr_down",  32'hE5110004, 1, 0, -1);
    run_instr("str_reset", 32'hE5810004, 0, 2, 4);
    run_instr("after_str_reset", 32'hE0821003, 0, 0, -1);
    run_instr("ldr_reset", 32'hE5910004, 0, 3, 4);
    run_instr("after_ldr_reset", 32'hEA000002, 0, 0, -1);
  endtask

  task automatic test_branch();
    run_instr("branch", 32'hEA000002, 0, 0, -1);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op3",  32'hEC000000, 0, 0, -1);
    run_instr("illegal_cmd1", 32'hE0221003, 0, 0, -1);
    run_instr("after_illegal", 32'hE2411001, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    int          rst_at;
    for (int n = 0; n < 300; n++) begin
      ins    = rand_instr();
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_instr("random", ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rst_at);
    end
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    instr     = '0;
    test_reset();
    test_dp();
    test_mem();
    test_branch();
    test_illegal();
    test_back_to_back();
    run_instr("final", 32'hE0821003, 0, 0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM that drives the CPU datapath, including the 2-bit ALU control code (0=ADD, 1=SUB, 2=AND, 3=ORR).
- Sequences each instruction through fetch, decode, execute, memory and writeback steps, selecting datapath muxes and strobes per step.
- Stalls on memory handshake via mem_ready.
- Supported subset: data-processing ADD/SUB/AND/ORR (register or immediate), LDR/STR with immediate offset, B. Condition field is ignored; all instructions execute.

Parameters:
- STATE_W, 4, width of the state register and of the state debug output.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  current instruction register contents, stable from DECODE onward.
- mem_ready  input  1  memory has completed the current access this cycle.
- ir_write  output  1  load the instruction register.
- pc_write  output  1  load the PC.
- mem_write  output  1  memory write request.
- reg_write  output  1  register-file write.
- adr_src  output  1  memory address select: 0=PC, 1=ALU-out register.
- alu_src_a  output  1  ALU A select: 0=reg A, 1=PC.
- alu_src_b  output  2  ALU B select: 0=reg B, 1=extended immediate, 2=constant 4.
- alu_ctrl  output  2  ALU operation: 0=ADD, 1=SUB, 2=AND, 3=ORR.
- result_src  output  2  result select: 0=ALU-out register, 1=read data, 2=ALU result.
- imm_src  output  2  extender mode: 0=8-bit data-processing, 1=12-bit memory, 2=24-bit branch.
- instr_done  output  1  one-cycle pulse in the final cycle of each legal instruction.
- illegal_instr  output  1  one-cycle pulse when DECODE rejects the instruction.
- state  output  STATE_W  current state, for debug.

Behaviour:
- Decode fields: op=instr[27:26]; I=instr[25]; cmd=instr[24:21]; L=instr[20]; U=instr[23].
- cmd map: 0100 gives ADD(0); 0010 gives SUB(1); 0000 gives AND(2); 1100 gives ORR(3). Any other cmd with op=00 is illegal. op=11 is illegal.
- States: FETCH, DECODE, EXECUTER, EXECUTEI, ALUWB, MEMADR, MEMREAD, MEMWB, MEMWRITE, BRANCH.
- Outputs are Moore per state. ir_write, pc_write and mem_ready-dependent transitions are additionally gated by mem_ready.
- Every output not listed for a state is 0.
- FETCH:
  - Drives adr_src=0, alu_src_a=1, alu_src_b=2, alu_ctrl=0, result_src=2.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives alu_src_a=1, alu_src_b=2, alu_ctrl=0; imm_src by op (00→0, 01→1, 10→2).
  - Next state: op=00 with I=0 → EXECUTER; op=00 with I=1 → EXECUTEI; op=01 → MEMADR; op=10 → BRANCH.
  - Illegal instruction: illegal_instr=1 and next state is FETCH; no strobes asserted.
- EXECUTER: alu_src_b=0, alu_ctrl=decoded code; next ALUWB.
- EXECUTEI: alu_src_b=1, imm_src=0, alu_ctrl=decoded code; next ALUWB.
- ALUWB: result_src=0, reg_write=1, instr_done=1; next FETCH.
- MEMADR: alu_src_b=1, imm_src=1, alu_ctrl=(U ? 0 : 1); next MEMREAD if L=1, else MEMWRITE.
- MEMREAD: adr_src=1; hold while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: result_src=1, reg_write=1, instr_done=1; next FETCH.
- MEMWRITE:
  - adr_src=1, mem_write=1, held every cycle until mem_ready=1.
  - In that cycle instr_done=1, then next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=1, imm_src=2, alu_ctrl=0, result_src=2, pc_write=1, instr_done=1; next FETCH.
- Reset:
  - While reset=1, all strobes (ir_write, pc_write, mem_write, reg_write, instr_done, illegal_instr) are forced 0 combinationally.
  - The state register loads FETCH on the next edge. This applies from any state, including mid-MEMWRITE or during a MEMREAD stall.
- Cycle counts with mem_ready=1 throughout: data-processing 4, LDR 5, STR 4, B 3, illegal 2.
- Unreachable state encodings go to FETCH with all outputs 0.

Test Plan:
- instr=0xE0821003 (ADD R1,R2,R3), mem_ready=1 → FETCH, DECODE, EXECUTER, ALUWB; alu_ctrl=0 and alu_src_b=0 in EXECUTER; reg_write=1 and instr_done=1 in cycle 4 only.
- instr=0xE2411001 (SUB R1,R1,#1) → EXECUTEI with alu_ctrl=1, alu_src_b=1, imm_src=0; then ALUWB; 4 cycles total.
- instr=0xE5910004 (LDR), mem_ready low for 2 cycles in MEMREAD → MEMADR has alu_ctrl=0 and imm_src=1; MEMREAD lasts 3 cycles; MEMWB has result_src=1, reg_write=1; 7 cycles total.
- instr=0xE5810004 (STR), mem_ready low for 2 cycles → mem_write=1 for 3 consecutive cycles, instr_done on the third, then FETCH. Repeat with reset asserted in the 2nd cycle → mem_write=0 that cycle and state=FETCH next.
- instr=0xEA000002 (B) → BRANCH has pc_write=1, imm_src=2, result_src=2; 3 cycles total.
- instr=0xEC000000 (op=11), then instr=0xE0221003 (cmd 0001) → illegal_instr pulses in DECODE, reg_write never asserted, next state FETCH; 2 cycles each.
